// File: rtl/instr_fetch.sv
// Instruction-fetch initiator: sequential PC, prefetch FIFO of {pc, instr}, valid/ready output.
// Optional FETCH_PERF_EN adds saturating stall/flush performance counters.
module instr_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_stall_cnt,
    output logic [31:0] perf_flush_cnt
`endif
);

    localparam int unsigned PW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   pc_mem_q    [FIFO_DEPTH];
    logic [31:0]   instr_mem_q [FIFO_DEPTH];
    logic          push, pop;

    assign imem_addr = fetch_pc_q;
    assign out_valid = (count_q != '0);
    assign out_pc    = pc_mem_q[rptr_q];
    assign out_instr = instr_mem_q[rptr_q];

    // Pop is taken before the redirect flush so a consumed head is never replayed.
    always_comb begin
        pop        = out_valid & out_ready;
        push       = ~redirect_valid & ((count_q < DEPTH_C) | pop);
        fetch_pc_d = fetch_pc_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        count_d    = count_q;
        if (redirect_valid) begin
            fetch_pc_d = redirect_pc & ~32'h3;
            wptr_d     = '0;
            rptr_d     = '0;
            count_d    = '0;
        end else begin
            if (push) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
                wptr_d     = wptr_q + 1'b1;
            end
            if (pop) begin
                rptr_d = rptr_q + 1'b1;
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q <= RESET_PC;
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                pc_mem_q[i]    <= '0;
                instr_mem_q[i] <= '0;
            end
        end else begin
            fetch_pc_q <= fetch_pc_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            if (push) begin
                pc_mem_q[wptr_q]    <= fetch_pc_q;
                instr_mem_q[wptr_q] <= imem_rdata;
            end
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] stall_cnt_q, flush_cnt_q;

    assign perf_stall_cnt = stall_cnt_q;
    assign perf_flush_cnt = flush_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (out_valid && !out_ready && stall_cnt_q != '1) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (redirect_valid && flush_cnt_q != '1) begin
                flush_cnt_q <= flush_cnt_q + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: queue-based fetch model, directed and random stimulus.
// Define FETCH_PERF_EN to also check the performance counters.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] imem_addr, imem_rdata, redirect_pc, out_instr, out_pc;
    logic        redirect_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic        out_valid;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_stall_cnt, perf_flush_cnt;
`endif

    int errors = 0;
    int checks = 0;

    logic [63:0] q[$];
    logic [31:0] mpc;
    logic [31:0] m_stall, m_flush;

    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return ((a >> 2) + 32'd1) * 32'h1111_1111;
    endfunction

    assign imem_rdata = memf(imem_addr);

    instr_fetch #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc(out_pc)
`ifdef FETCH_PERF_EN
        , .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
`endif
    );

    // Advance the reference model by one clock edge, then move to 1 time unit past it.
    task automatic tick();
        bit mvalid, pop, push;
        mvalid = (q.size() != 0);
        pop    = mvalid && out_ready;
        push   = !redirect_valid && (q.size() < 2 || pop);
        if (mvalid && !out_ready && m_stall != 32'hFFFF_FFFF) m_stall++;
        if (redirect_valid && m_flush != 32'hFFFF_FFFF) m_flush++;
        if (pop) void'(q.pop_front());
        if (redirect_valid) begin
            q.delete();
            mpc = redirect_pc & 32'hFFFF_FFFC;
        end else if (push) begin
            q.push_back({mpc, memf(mpc)});
            mpc = mpc + 32'd4;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        out_ready      = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        q.delete();
        mpc     = 32'h0;
        m_stall = '0;
        m_flush = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        if (out_valid !== 1'b0 || imem_addr !== 32'h0) begin
            errors++;
            $display("FAIL reset_state valid=%b addr=%h required valid=0 addr=00000000", out_valid, imem_addr);
        end
        checks++;
        out_ready = 1'b1;
        repeat (3) tick();
        #2;
        rst_n = 1'b0;
        q.delete();
        mpc = 32'h0; m_stall = '0; m_flush = '0;
        #1;
        if (out_valid !== 1'b0 || imem_addr !== 32'h0) begin
            errors++;
            $display("FAIL async_reset valid=%b addr=%h required valid=0 addr=00000000", out_valid, imem_addr);
        end
        checks++;
`ifdef FETCH_PERF_EN
        if (perf_stall_cnt !== 32'h0 || perf_flush_cnt !== 32'h0) begin
            errors++;
            $display("FAIL async_reset_perf stall=%0d flush=%0d required 0 0", perf_stall_cnt, perf_flush_cnt);
        end
        checks++;
`endif
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_stream();
        do_reset();
        out_ready = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) begin
            if (out_valid !== 1'b1 || out_pc !== 32'(4 * i) || out_instr !== memf(32'(4 * i))) begin
                errors++;
                $display("FAIL stream i=%0d valid=%b pc=%h instr=%h required valid=1 pc=%h instr=%h",
                         i, out_valid, out_pc, out_instr, 32'(4 * i), memf(32'(4 * i)));
            end
            checks++;
            tick();
        end
    endtask

    task automatic test_stall();
        do_reset();
        out_ready = 1'b0;
        repeat (5) tick();
        if (imem_addr !== 32'h8 || out_pc !== 32'h0 || out_valid !== 1'b1 || out_instr !== 32'h1111_1111) begin
            errors++;
            $display("FAIL stall_hold addr=%h pc=%h valid=%b instr=%h required addr=00000008 pc=00000000 valid=1 instr=11111111",
                     imem_addr, out_pc, out_valid, out_instr);
        end
        checks++;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (out_valid !== 1'b1 || out_pc !== 32'(4 * i)) begin
                errors++;
                $display("FAIL stall_release i=%0d valid=%b pc=%h required valid=1 pc=%h", i, out_valid, out_pc, 32'(4 * i));
            end
            checks++;
            tick();
        end
    endtask

    task automatic test_redirect();
        logic [31:0] targets [3];
        logic [31:0] starts  [3];
        targets = '{32'h40, 32'h23, 32'hFFFF_FFFC};
        starts  = '{32'h40, 32'h20, 32'hFFFF_FFFC};
        for (int t = 0; t < 3; t++) begin
            do_reset();
            out_ready = 1'b0;
            repeat (3) tick();
            out_ready      = 1'b1;
            redirect_valid = 1'b1;
            redirect_pc    = targets[t];
            tick();
            redirect_valid = 1'b0;
            if (out_valid !== 1'b0 || imem_addr !== starts[t]) begin
                errors++;
                $display("FAIL redirect_bubble t=%0d valid=%b addr=%h required valid=0 addr=%h", t, out_valid, imem_addr, starts[t]);
            end
            checks++;
            tick();
            for (int i = 0; i < 2; i++) begin
                if (out_valid !== 1'b1 || out_pc !== starts[t] + 32'(4 * i) || out_instr !== memf(starts[t] + 32'(4 * i))) begin
                    errors++;
                    $display("FAIL redirect_path t=%0d i=%0d valid=%b pc=%h instr=%h required pc=%h instr=%h",
                             t, i, out_valid, out_pc, out_instr, starts[t] + 32'(4 * i), memf(starts[t] + 32'(4 * i)));
                end
                checks++;
                tick();
            end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        out_ready = 1'b1;
        repeat (3) tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        tick();
        redirect_pc    = 32'h200;
        tick();
        redirect_valid = 1'b0;
        if (out_valid !== 1'b0 || imem_addr !== 32'h200) begin
            errors++;
            $display("FAIL b2b_redirect valid=%b addr=%h required valid=0 addr=00000200", out_valid, imem_addr);
        end
        checks++;
        tick();
        if (out_valid !== 1'b1 || out_pc !== 32'h200 || out_instr !== memf(32'h200)) begin
            errors++;
            $display("FAIL b2b_first valid=%b pc=%h instr=%h required valid=1 pc=00000200 instr=%h",
                     out_valid, out_pc, out_instr, memf(32'h200));
        end
        checks++;
    endtask

    task automatic test_random();
        logic [63:0] head;
        do_reset();
        for (int c = 0; c < 300; c++) begin
            out_ready      = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 9) == 0);
            redirect_pc    = $urandom;
            head = (q.size() != 0) ? q[0] : 64'h0;
            if (out_valid !== (q.size() != 0) || imem_addr !== mpc ||
                (q.size() != 0 && {out_pc, out_instr} !== head)) begin
                errors++;
                $display("FAIL random c=%0d valid=%b pc=%h instr=%h addr=%h required valid=%b head=%h addr=%h",
                         c, out_valid, out_pc, out_instr, imem_addr, (q.size() != 0), head, mpc);
            end
            checks++;
`ifdef FETCH_PERF_EN
            if (perf_stall_cnt !== m_stall || perf_flush_cnt !== m_flush) begin
                errors++;
                $display("FAIL random_perf c=%0d stall=%0d flush=%0d required %0d %0d",
                         c, perf_stall_cnt, perf_flush_cnt, m_stall, m_flush);
            end
            checks++;
`endif
            tick();
        end
        redirect_valid = 1'b0;
    endtask

`ifdef FETCH_PERF_EN
    task automatic test_perf();
        do_reset();
        out_ready = 1'b0;
        repeat (4) tick();
        out_ready      = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h80;
        repeat (2) tick();
        redirect_valid = 1'b0;
        tick();
        if (perf_stall_cnt !== 32'd3 || perf_flush_cnt !== 32'd2) begin
            errors++;
            $display("FAIL perf_counts stall=%0d flush=%0d required 3 2", perf_stall_cnt, perf_flush_cnt);
        end
        checks++;
        #2;
        rst_n = 1'b0;
        #1;
        if (perf_stall_cnt !== 32'h0 || perf_flush_cnt !== 32'h0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL perf_async_reset stall=%0d flush=%0d valid=%b required 0 0 0",
                     perf_stall_cnt, perf_flush_cnt, out_valid);
        end
        checks++;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask
`endif

    initial begin
        redirect_pc = '0;
        mpc = '0; m_stall = '0; m_flush = '0;
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_back_to_back();
        test_random();
`ifdef FETCH_PERF_EN
        test_perf();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
